// File: rtl/aib_avmm_bridge_pkg.sv
// Shared types and constants for the AIB AVMM channel bridge.
// Holds the FSM state encoding, the default error read data, the broadcast
// channel id and small channel-selector helpers used by the bridge top.
package aib_avmm_bridge_pkg;

    // Bridge transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } bridge_state_e;

    // Read data returned upstream on a bad channel id or timeout
    localparam logic [31:0] ERR_RDATA_DFLT = 32'hDEAD_BEEF;

    // Channel id reserved for broadcast writes (all ones)
    localparam logic [5:0] BCAST_ID = 6'h3F;

    // Channel selector as carried on the config bus (up to 63 channels)
    typedef logic [5:0] chnl_sel_t;

    // True when the selector addresses an existing channel
    function automatic logic chnl_in_range(input chnl_sel_t id, input int num_chnl);
        return (32'(id) < 32'(num_chnl));
    endfunction

    // True when the selector is the broadcast id
    function automatic logic chnl_is_bcast(input chnl_sel_t id);
        return (id == BCAST_ID);
    endfunction

endpackage

// File: rtl/aib_avmm_timeout_cnt.sv
// Saturating wait counter for the AVMM bridge.
// clr_i zeroes the count; en_i advances it by one per cycle, stopping at
// TIMEOUT_CYC. expired_o flags the cycle in which the TIMEOUT_CYC-th waiting
// cycle ends, so the owner can leave its wait state on that clock edge.
module aib_avmm_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC);
    localparam logic [15:0] LAST  = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear has priority, then saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i & (cnt_q >= LAST);

endmodule

// File: rtl/aib_avmm_chnl_bridge.sv
// Config-bus bridge from the single adapter AVMM port to NUM_CHNL channel
// AVMM slaves. One transaction at a time is steered to the channel named by
// i_channel_id; waitreq/read data are returned upstream, with a per-transaction
// timeout and an error response for bad ids or unresponsive channels.
// Optional feature macro: AIB_AVMM_BRIDGE_BCAST_EN (all-ones id broadcasts
// writes to every channel); without it that id is treated as out of range.
module aib_avmm_chnl_bridge
    import aib_avmm_bridge_pkg::*;
#(
    parameter int NUM_CHNL    = 24,
    parameter int CHNL_ID_W   = 6,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DFLT)
) (
    input  logic                         i_cfg_avmm_clk,
    input  logic                         i_cfg_avmm_rst_n,
    input  logic [CHNL_ID_W-1:0]         i_channel_id,
    input  logic [ADDR_W-1:0]            i_cfg_avmm_addr,
    input  logic [DATA_W/8-1:0]          i_cfg_avmm_byte_en,
    input  logic                         i_cfg_avmm_read,
    input  logic                         i_cfg_avmm_write,
    input  logic [DATA_W-1:0]            i_cfg_avmm_wdata,
    output logic [DATA_W-1:0]            o_cfg_avmm_rdata,
    output logic                         o_cfg_avmm_rdatavld,
    output logic                         o_cfg_avmm_waitreq,
    output logic [ADDR_W-1:0]            o_chnl_avmm_addr,
    output logic [DATA_W/8-1:0]          o_chnl_avmm_byte_en,
    output logic [DATA_W-1:0]            o_chnl_avmm_wdata,
    output logic [NUM_CHNL-1:0]          o_chnl_avmm_read,
    output logic [NUM_CHNL-1:0]          o_chnl_avmm_write,
    input  logic [NUM_CHNL*DATA_W-1:0]   i_chnl_avmm_rdata,
    input  logic [NUM_CHNL-1:0]          i_chnl_avmm_rdatavld,
    input  logic [NUM_CHNL-1:0]          i_chnl_avmm_waitreq,
    output logic                         o_err_sticky
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [NUM_CHNL-1:0] ALL_CHNL = {NUM_CHNL{1'b1}};

    bridge_state_e       state_q, state_d;
    logic                op_wr_q, op_wr_d;     // latched operation: 1 = write
    logic                err_q, err_d;         // current transaction is an error
    logic                bcast_q, bcast_d;     // current transaction is a broadcast
    logic [NUM_CHNL-1:0] sel_q, sel_d;         // one-hot selected channel(s)
    logic [NUM_CHNL-1:0] mask_q, mask_d;       // broadcast: channels that accepted
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_CHNL-1:0] rd_strb_q, rd_strb_d;
    logic [NUM_CHNL-1:0] wr_strb_q, wr_strb_d;
    logic                waitreq_q, waitreq_d;
    logic                rdatavld_q, rdatavld_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sticky_q, sticky_d;

    chnl_sel_t           id_s;
    logic                req_s;
    logic                id_ok_s;
    logic                bcast_hit_s;
    logic [NUM_CHNL-1:0] sel_new_s;
    logic                sel_acc_s;
    logic                sel_vld_s;
    logic [NUM_CHNL-1:0] bc_acc_s;
    logic [DATA_W-1:0]   rdata_mux_s;
    logic                cnt_clr_s;
    logic                cnt_en_s;
    logic                tmo_s;

    assign id_s      = chnl_sel_t'(i_channel_id);
    assign req_s     = i_cfg_avmm_read | i_cfg_avmm_write;
    assign id_ok_s   = chnl_in_range(id_s, NUM_CHNL);
    assign sel_new_s = NUM_CHNL'(1) << id_s;
    assign sel_acc_s = |(sel_q & ~i_chnl_avmm_waitreq);
    assign sel_vld_s = |(sel_q & i_chnl_avmm_rdatavld);
    assign bc_acc_s  = wr_strb_q & ~i_chnl_avmm_waitreq;
    assign cnt_en_s  = (state_q == ST_REQ) || (state_q == ST_RDWAIT);

`ifdef AIB_AVMM_BRIDGE_BCAST_EN
    assign bcast_hit_s = chnl_is_bcast(id_s);
`else
    assign bcast_hit_s = 1'b0;
`endif

    // Wait budget for the transaction in flight
    aib_avmm_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i     (i_cfg_avmm_clk),
        .rst_ni    (i_cfg_avmm_rst_n),
        .clr_i     (cnt_clr_s),
        .en_i      (cnt_en_s),
        .expired_o (tmo_s)
    );

    // Read data mux: pick the selected channel's read data bus
    always_comb begin
        rdata_mux_s = '0;
        for (int k = 0; k < NUM_CHNL; k++) begin
            if (sel_q[k]) begin
                rdata_mux_s = rdata_mux_s | i_chnl_avmm_rdata[k*DATA_W +: DATA_W];
            end else begin
                rdata_mux_s = rdata_mux_s;
            end
        end
    end

    // Transaction FSM: next state, strobes, captured fields and upstream response
    always_comb begin
        state_d    = state_q;
        op_wr_d    = op_wr_q;
        err_d      = err_q;
        bcast_d    = bcast_q;
        sel_d      = sel_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_strb_d  = '0;
        wr_strb_d  = '0;
        rdata_d    = rdata_q;
        sticky_d   = sticky_q;
        cnt_clr_s  = 1'b0;
        waitreq_d  = 1'b1;
        rdatavld_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    // Write wins when both request lines are high
                    op_wr_d = i_cfg_avmm_write;
                    addr_d  = i_cfg_avmm_addr;
                    be_d    = i_cfg_avmm_byte_en;
                    wdata_d = i_cfg_avmm_wdata;
                    err_d   = 1'b0;
                    bcast_d = 1'b0;
                    mask_d  = '0;
                    if (bcast_hit_s) begin
                        bcast_d = 1'b1;
                        sel_d   = ALL_CHNL;
                        if (i_cfg_avmm_write) begin
                            wr_strb_d = ALL_CHNL;
                            cnt_clr_s = 1'b1;
                            state_d   = ST_REQ;
                        end else begin
                            // Broadcast reads have no meaningful answer
                            err_d    = 1'b1;
                            sticky_d = 1'b1;
                            rdata_d  = ERR_RDATA;
                            state_d  = ST_DONE;
                        end
                    end else if (!id_ok_s) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        sel_d    = '0;
                        if (i_cfg_avmm_write) begin
                            rdata_d = rdata_q;
                        end else begin
                            rdata_d = ERR_RDATA;
                        end
                        state_d  = ST_DONE;
                    end else begin
                        sel_d     = sel_new_s;
                        cnt_clr_s = 1'b1;
                        state_d   = ST_REQ;
                        if (i_cfg_avmm_write) begin
                            wr_strb_d = sel_new_s;
                        end else begin
                            rd_strb_d = sel_new_s;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (bcast_q) begin
                    // Each channel's strobe drops on its own accept
                    mask_d = mask_q | bc_acc_s;
                    if (&(mask_q | bc_acc_s)) begin
                        state_d = ST_DONE;
                    end else if (tmo_s) begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        wr_strb_d = wr_strb_q & ~bc_acc_s;
                    end
                end else if (sel_acc_s) begin
                    if (op_wr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (tmo_s) begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = ST_DONE;
                    if (op_wr_q) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d = ERR_RDATA;
                    end
                end else begin
                    rd_strb_d = rd_strb_q;
                    wr_strb_d = wr_strb_q;
                end
            end

            ST_RDWAIT: begin
                // Only the selected channel's rdatavld is honoured
                if (sel_vld_s) begin
                    rdata_d = rdata_mux_s;
                    state_d = ST_DONE;
                end else if (tmo_s) begin
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    rdata_d  = ERR_RDATA;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_RDWAIT;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Upstream handshake is presented during the single DONE cycle
        if (state_d == ST_DONE) begin
            waitreq_d  = 1'b0;
            rdatavld_d = ~op_wr_d;
        end else begin
            waitreq_d  = 1'b1;
            rdatavld_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q    <= ST_IDLE;
            op_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            bcast_q    <= 1'b0;
            sel_q      <= '0;
            mask_q     <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_strb_q  <= '0;
            wr_strb_q  <= '0;
            waitreq_q  <= 1'b1;
            rdatavld_q <= 1'b0;
            rdata_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_wr_q    <= op_wr_d;
            err_q      <= err_d;
            bcast_q    <= bcast_d;
            sel_q      <= sel_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_strb_q  <= rd_strb_d;
            wr_strb_q  <= wr_strb_d;
            waitreq_q  <= waitreq_d;
            rdatavld_q <= rdatavld_d;
            rdata_q    <= rdata_d;
            sticky_q   <= sticky_d;
        end
    end

    assign o_cfg_avmm_rdata    = rdata_q;
    assign o_cfg_avmm_rdatavld = rdatavld_q;
    assign o_cfg_avmm_waitreq  = waitreq_q;
    assign o_chnl_avmm_addr    = addr_q;
    assign o_chnl_avmm_byte_en = be_q;
    assign o_chnl_avmm_wdata   = wdata_q;
    assign o_chnl_avmm_read    = rd_strb_q;
    assign o_chnl_avmm_write   = wr_strb_q;
    assign o_err_sticky        = sticky_q;

endmodule

// File: doc/aib_avmm_chnl_bridge.md
Name: aib_avmm_chnl_bridge

Overview:
Parametrised config-bus bridge between the single adapter AVMM config port and NUM_CHNL per-channel AVMM slaves. Decodes i_channel_id, steers one transaction at a time to the selected channel, and returns waitreq and read data upstream. Adds per-transaction timeout and error response, which the single-channel config path lacks. Sits between the config master and the channel adapter register blocks.

Parameters:
NUM_CHNL, 24, number of downstream channels (1..63)
CHNL_ID_W, 6, width of i_channel_id
ADDR_W, 17, AVMM address width
DATA_W, 32, AVMM data width (byte_en width = DATA_W/8)
TIMEOUT_CYC, 255, max cycles waiting on downstream waitreq/rdatavld (1..65535)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error/timeout

Ports:
i_cfg_avmm_clk  in  1  single clock
i_cfg_avmm_rst_n  in  1  reset, asynchronous, active-low
i_channel_id  in  CHNL_ID_W  target channel, sampled with request
i_cfg_avmm_addr  in  ADDR_W  upstream address
i_cfg_avmm_byte_en  in  DATA_W/8  upstream byte enables
i_cfg_avmm_read  in  1  upstream read request
i_cfg_avmm_write  in  1  upstream write request
i_cfg_avmm_wdata  in  DATA_W  upstream write data
o_cfg_avmm_rdata  out  DATA_W  upstream read data
o_cfg_avmm_rdatavld  out  1  upstream read data valid pulse
o_cfg_avmm_waitreq  out  1  upstream wait request
o_chnl_avmm_addr  out  ADDR_W  shared downstream address (registered)
o_chnl_avmm_byte_en  out  DATA_W/8  shared downstream byte enables
o_chnl_avmm_wdata  out  DATA_W  shared downstream write data
o_chnl_avmm_read  out  NUM_CHNL  per-channel read strobe
o_chnl_avmm_write  out  NUM_CHNL  per-channel write strobe
i_chnl_avmm_rdata  in  NUM_CHNL*DATA_W  per-channel read data, channel k at [k*DATA_W +: DATA_W]
i_chnl_avmm_rdatavld  in  NUM_CHNL  per-channel read data valid
i_chnl_avmm_waitreq  in  NUM_CHNL  per-channel wait request
o_err_sticky  out  1  set on timeout or bad channel id; cleared only by reset

Behaviour:
- Reset: all outputs 0 except o_cfg_avmm_waitreq=1; FSM in IDLE; timeout counter 0. Assertion mid-transaction drops downstream strobes immediately (async); transaction abandoned, no upstream response.
- FSM states: IDLE, REQ, RDWAIT, DONE.
- IDLE: waitreq=1. On read|write: latch id/addr/be/wdata/op; write wins if both high. If id >= NUM_CHNL -> DONE with error; else -> REQ.
- REQ: drive selected channel strobe (one-hot, all others 0). Selected i_chnl_avmm_waitreq==0 at clock edge -> write: DONE; read: RDWAIT, strobe drops next cycle.
- RDWAIT: on selected i_chnl_avmm_rdatavld, capture rdata -> DONE. rdatavld on non-selected channels ignored.
- DONE (one cycle): o_cfg_avmm_waitreq=0; for reads o_cfg_avmm_rdatavld=1 with captured data (ERR_RDATA on error). Next state IDLE. Master must drop request after seeing waitreq=0; a request still high in the following IDLE cycle is a new transaction.
- Latency (zero-wait slave): write IDLE->REQ->DONE = 2 cycles after request; read with rdatavld one cycle after accept = 3 cycles.
- Timeout: counter clears on entry to REQ, increments each REQ/RDWAIT cycle; at TIMEOUT_CYC -> DONE with ERR_RDATA (reads), set o_err_sticky, drop strobes. Counter saturates, never wraps.
- Bad channel id also sets o_err_sticky; writes discarded.
- o_cfg_avmm_rdata holds last value between pulses.

Optional Feature:
AIB_AVMM_BRIDGE_BCAST_EN: id == all-ones (6'h3F) is broadcast. Write asserts all NUM_CHNL write strobes; each strobe drops individually when its waitreq is low; done mask tracked; DONE when mask full; timeout applies to the whole broadcast. Broadcast read returns ERR_RDATA and sets o_err_sticky. Without macro: all-ones id is out-of-range, handled as bad id.

Decomposition:
- Package aib_avmm_bridge_pkg: FSM state enum, ERR_RDATA default, BCAST_ID constant, chnl_sel_t helpers.
- Sub-module aib_avmm_timeout_cnt: clear/enable/saturating counter with expired flag, parametrised by TIMEOUT_CYC.

Test Plan:
- Write id=3, addr=17'h00208, wdata=32'h1234_5678, ch3 waitreq low -> only o_chnl_avmm_write[3] pulses 1 cycle with those values; upstream waitreq low 2 cycles after request.
- Read id=5, ch5 waitreq high 4 cycles, rdatavld 2 cycles later with 32'hA5A5_0001 -> upstream rdatavld pulse with 32'hA5A5_0001; other channels untouched.
- Read id=30 (NUM_CHNL=24) -> no downstream strobe, rdata=32'hDEAD_BEEF, o_err_sticky=1.
- Read id=0, ch0 never returns rdatavld, TIMEOUT_CYC=16 -> DONE 16 cycles after entering REQ, ERR_RDATA returned, sticky set, strobes low.
- Reset asserted while in RDWAIT -> strobes and rdatavld 0 immediately, waitreq 1; next read after reset completes normally.
- With AIB_AVMM_BRIDGE_BCAST_EN, write id=6'h3F, ch2 waitreq held 3 extra cycles -> all write strobes pulse, ch2 strobe held until accepted, single upstream completion after ch2.
